instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I/M instruction encoder: packs decoded fields into a 32-bit word and queues it in a small FIFO.
// Illegal field combinations are rejected with a one-cycle error pulse and a saturating reject count.
module instr_encoder #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 16
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iValid,
   output logic            oReady,
   input  logic [6:0]      iOpClass,
   input  logic [4:0]      iALUControl,
   input  logic [2:0]      iFunct3,
   input  logic [4:0]      iRd,
   input  logic [4:0]      iRs1,
   input  logic [4:0]      iRs2,
   input  logic [31:0]     iImm,
   output logic [31:0]     oInstr,
   output logic            oValid,
   input  logic            iReady,
   output logic            oErr,
   output logic [7:0]      oErrCnt,
   output logic [CNTW-1:0] oInstrCnt
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Base ops 0..7 carry their funct3 in the low bits; RV32M ops occupy 16..23 the same way.
   localparam logic [4:0] OPSLL = 5'd1;
   localparam logic [4:0] OPSRL = 5'd5;
   localparam logic [4:0] OPSUB = 5'd8;
   localparam logic [4:0] OPSRA = 5'd9;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic signed [31:0] w_simm;
   logic        w_base, w_mul, w_shift, w_alu_ok;
   logic        w_i_ok, w_b_ok, w_j_ok, w_u_ok, w_sh_ok;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_word;
   logic        w_ok, w_acc, w_push, w_pop;

   logic [31:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [AW:0]     r_cnt;
   logic            r_err;
   logic [7:0]      r_errcnt;
   logic [CNTW-1:0] r_instrcnt;

   assign w_simm  = $signed(iImm);
   assign w_base  = (iALUControl[4:3] == 2'b00);
   assign w_mul   = (iALUControl[4:3] == 2'b10);
   assign w_shift = (iALUControl == OPSLL) || (iALUControl == OPSRL) || (iALUControl == OPSRA);
   assign w_alu_ok = w_base || w_mul || (iALUControl == OPSUB) || (iALUControl == OPSRA);
   assign w_i_ok  = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
   assign w_b_ok  = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !iImm[0];
   assign w_j_ok  = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !iImm[0];
   assign w_u_ok  = (iImm[11:0] == 12'h000);
   assign w_sh_ok = (iImm[31:5] == 27'd0);

   always_comb begin
      w_f3 = iALUControl[2:0];
      w_f7 = 7'b0000000;
      if (iALUControl == OPSUB) begin
         w_f3 = 3'b000;
         w_f7 = 7'b0100000;
      end else if (iALUControl == OPSRA) begin
         w_f3 = 3'b101;
         w_f7 = 7'b0100000;
      end else if (w_mul) begin
         w_f7 = 7'b0000001;
      end
   end

   always_comb begin
      w_word = 32'h0;
      w_ok   = 1'b0;
      case (iOpClass)
         OPC_LOAD: begin
            w_ok   = w_i_ok && (iFunct3 != 3'd3) && (iFunct3 != 3'd6) && (iFunct3 != 3'd7);
            w_word = {iImm[11:0], iRs1, iFunct3, iRd, iOpClass};
         end
         OPC_OPIMM: begin
            if (w_shift) begin
               w_ok   = w_sh_ok;
               w_word = {w_f7, iImm[4:0], iRs1, w_f3, iRd, iOpClass};
            end else begin
               w_ok   = w_i_ok && w_base;
               w_word = {iImm[11:0], iRs1, w_f3, iRd, iOpClass};
            end
         end
         OPC_AUIPC, OPC_LUI: begin
            w_ok   = w_u_ok;
            w_word = {iImm[31:12], iRd, iOpClass};
         end
         OPC_STORE: begin
            w_ok   = w_i_ok && (iFunct3 <= 3'd2);
            w_word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpClass};
         end
         OPC_RTYPE: begin
            w_ok   = w_alu_ok;
            w_word = {w_f7, iRs2, iRs1, w_f3, iRd, iOpClass};
         end
         OPC_BRANCH: begin
            w_ok   = w_b_ok && (iFunct3 != 3'd2) && (iFunct3 != 3'd3);
            w_word = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], iOpClass};
         end
         OPC_JALR: begin
            w_ok   = w_i_ok && (iFunct3 == 3'd0);
            w_word = {iImm[11:0], iRs1, iFunct3, iRd, iOpClass};
         end
         OPC_JAL: begin
            w_ok   = w_j_ok;
            w_word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, iOpClass};
         end
         default: begin
            w_ok   = 1'b0;
            w_word = 32'h0;
         end
      endcase
   end

   assign oReady = (r_cnt < CNT_FULL);
   assign oValid = (r_cnt != '0);
   assign w_acc  = iValid && oReady && !iRST;
   assign w_push = w_acc && w_ok;
   assign w_pop  = oValid && iReady && !iRST;

   // FIFO storage holds data only, so it is written without reset.
   always_ff @(posedge iCLK) begin
      if (w_push) r_mem[r_wr] <= w_word;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_errcnt   <= 8'd0;
         r_instrcnt <= '0;
      end else begin
         r_err <= w_acc && !w_ok;
         if (w_acc && !w_ok) r_errcnt <= sat_inc8(r_errcnt);
         if (w_push) begin
            r_wr       <= r_wr + AW'(1);
            r_instrcnt <= r_instrcnt + CNTW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
      end
   end

   assign oInstr    = oValid ? r_mem[r_rd] : 32'h0;
   assign oErr      = r_err;
   assign oErrCnt   = r_errcnt;
   assign oInstrCnt = r_instrcnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table through a scoreboard queue, plus
// backpressure, simultaneous push/pop, error saturation and reset-with-traffic sequences.
module tb_instr_encoder;
   localparam int DEPTH = 4;
   localparam int CNTW  = 16;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_RTYPE  = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic [4:0] OPADD = 5'd0;
   localparam logic [4:0] OPSLL = 5'd1;
   localparam logic [4:0] OPSUB = 5'd8;
   localparam logic [4:0] OPSRA = 5'd9;
   localparam logic [4:0] OPMUL = 5'd16;

   logic            iCLK = 1'b0;
   logic            iRST = 1'b1;
   logic            iValid = 1'b0;
   logic            oReady;
   logic [6:0]      iOpClass = '0;
   logic [4:0]      iALUControl = '0;
   logic [2:0]      iFunct3 = '0;
   logic [4:0]      iRd = '0, iRs1 = '0, iRs2 = '0;
   logic [31:0]     iImm = '0;
   logic [31:0]     oInstr;
   logic            oValid;
   logic            iReady = 1'b0;
   logic            oErr;
   logic [7:0]      oErrCnt;
   logic [CNTW-1:0] oInstrCnt;

   instr_encoder #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
      .iOpClass(iOpClass), .iALUControl(iALUControl), .iFunct3(iFunct3),
      .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
      .oInstr(oInstr), .oValid(oValid), .iReady(iReady),
      .oErr(oErr), .oErrCnt(oErrCnt), .oInstrCnt(oInstrCnt)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  alu;
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      bit          ok;
      logic [31:0] word;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] q[$];
   logic [31:0] e_mon;
   int          tests = 0, fails = 0;
   int          mcnt = 0, merr = 0;
   bit          mon_en = 1'b0;

   function automatic vec_t mk(logic [6:0] op, logic [4:0] alu, logic [2:0] f3, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm, bit ok,
                               logic [31:0] word);
      vec_t v;
      v.op = op; v.alu = alu; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.ok = ok; v.word = word;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every word leaving the FIFO must match the oldest expected word.
   always @(negedge iCLK) begin
      if (mon_en && !iRST && oValid === 1'b1 && iReady) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h expected no output", oInstr);
         end else begin
            e_mon = q.pop_front();
            chk("fifo_word", oInstr, e_mon);
         end
      end
   end

   task automatic drive(input vec_t v);
      iOpClass = v.op; iALUControl = v.alu; iFunct3 = v.f3;
      iRd = v.rd; iRs1 = v.rs1; iRs2 = v.rs2; iImm = v.imm;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic req(input vec_t v, input int maxcyc);
      bit acc, r;
      acc = 1'b0;
      drive(v);
      iValid = 1'b1;
      for (int c = 0; c < maxcyc && !acc; c++) begin
         @(negedge iCLK);
         r = oReady;
         @(posedge iCLK);
         #1;
         if (r) acc = 1'b1;
      end
      iValid = 1'b0;
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no accept expected accept within %0d cycles", maxcyc);
      end else begin
         if (v.ok) begin
            q.push_back(v.word);
            mcnt++;
         end else if (merr < 255) begin
            merr++;
         end
         chk("err_pulse", 32'(oErr), v.ok ? 32'd0 : 32'd1);
         chk("err_cnt", 32'(oErrCnt), 32'(merr));
         chk("instr_cnt", 32'(oInstrCnt), 32'(mcnt));
      end
   endtask

   task automatic drain();
      iReady = 1'b1;
      for (int c = 0; c < 20 && q.size() != 0; c++) begin
         @(posedge iCLK);
         #1;
      end
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d words left expected 0", q.size());
      end
      @(posedge iCLK);
      #1;
      chk("drained_valid", 32'(oValid), 32'd0);
   endtask

   function automatic vec_t addi(int k);
      return mk(OPC_OPIMM, OPADD, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k), 1'b1,
                (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13);
   endfunction

   initial begin
      vec_t fifth, bad;

      tbl.push_back(mk(OPC_OPIMM,  OPADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,          1, 32'h00500093));
      tbl.push_back(mk(OPC_RTYPE,  OPSUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h402081B3));
      tbl.push_back(mk(OPC_OPIMM,  OPSRA, 3'd0, 5'd5, 5'd5, 5'd0, 32'd3,          1, 32'h4032D293));
      tbl.push_back(mk(OPC_BRANCH, OPADD, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4,        1, 32'hFE208EE3));
      tbl.push_back(mk(OPC_BRANCH, OPADD, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3,          0, 32'h0));
      tbl.push_back(mk(OPC_BRANCH, OPADD, 3'd1, 5'd0, 5'd0, 5'd0, 32'd4094,       1, 32'h7E001FE3));
      tbl.push_back(mk(OPC_BRANCH, OPADD, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8,          0, 32'h0));
      tbl.push_back(mk(OPC_LUI,    OPADD, 3'd5, 5'd1, 5'd0, 5'd0, 32'h12345000,   1, 32'h123450B7));
      tbl.push_back(mk(OPC_LUI,    OPADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345001,   0, 32'h0));
      tbl.push_back(mk(OPC_AUIPC,  OPADD, 3'd0, 5'd2, 5'd0, 5'd0, 32'hFFFFF000,   1, 32'hFFFFF117));
      tbl.push_back(mk(OPC_LOAD,   OPADD, 3'd2, 5'd2, 5'd3, 5'd0, -32'sd1,        1, 32'hFFF1A103));
      tbl.push_back(mk(OPC_LOAD,   OPADD, 3'd3, 5'd2, 5'd3, 5'd0, 32'd0,          0, 32'h0));
      tbl.push_back(mk(OPC_STORE,  OPADD, 3'd2, 5'd0, 5'd2, 5'd5, 32'd8,          1, 32'h00512423));
      tbl.push_back(mk(OPC_STORE,  OPADD, 3'd3, 5'd0, 5'd2, 5'd5, 32'd8,          0, 32'h0));
      tbl.push_back(mk(OPC_OPIMM,  OPADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,       0, 32'h0));
      tbl.push_back(mk(OPC_OPIMM,  OPADD, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd2048,     1, 32'h80000093));
      tbl.push_back(mk(OPC_OPIMM,  OPSUB, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1,          0, 32'h0));
      tbl.push_back(mk(OPC_OPIMM,  OPSLL, 3'd0, 5'd1, 5'd0, 5'd0, 32'd32,         0, 32'h0));
      tbl.push_back(mk(OPC_JAL,    OPADD, 3'd7, 5'd1, 5'd0, 5'd0, 32'd2048,       1, 32'h001000EF));
      tbl.push_back(mk(OPC_JAL,    OPADD, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd1048576,  1, 32'h800000EF));
      tbl.push_back(mk(OPC_JAL,    OPADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1048576,    0, 32'h0));
      tbl.push_back(mk(OPC_JALR,   OPADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd4,          1, 32'h004100E7));
      tbl.push_back(mk(OPC_JALR,   OPADD, 3'd1, 5'd1, 5'd2, 5'd0, 32'd4,          0, 32'h0));
      tbl.push_back(mk(OPC_RTYPE,  OPMUL, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,          1, 32'h023100B3));
      tbl.push_back(mk(7'h7F,      OPADD, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,          0, 32'h0));

      repeat (3) @(posedge iCLK);
      #1;
      iRST = 1'b0;
      chk("rst_valid", 32'(oValid), 32'd0);
      chk("rst_err", 32'(oErr), 32'd0);
      chk("rst_errcnt", 32'(oErrCnt), 32'd0);
      chk("rst_instrcnt", 32'(oInstrCnt), 32'd0);
      chk("rst_instr", oInstr, 32'h0);
      chk("rst_ready", 32'(oReady), 32'd1);
      mon_en = 1'b1;

      iReady = 1'b1;
      foreach (tbl[i]) req(tbl[i], 10);
      drain();

      // Backpressure: fill, hold a fifth request while full, then release.
      iReady = 1'b0;
      for (int k = 0; k < DEPTH; k++) req(addi(k), 10);
      chk("full_ready", 32'(oReady), 32'd0);
      fifth = addi(DEPTH);
      drive(fifth);
      iValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge iCLK);
         #1;
         chk("stall_ready", 32'(oReady), 32'd0);
         chk("stall_valid", 32'(oValid), 32'd1);
         chk("stall_head", oInstr, q[0]);
         chk("stall_instrcnt", 32'(oInstrCnt), 32'(mcnt));
      end
      iReady = 1'b1;
      req(fifth, 10);
      drain();

      // Half-full push with pop: occupancy stays, so two more pushes fill it exactly.
      iReady = 1'b0;
      req(addi(10), 10);
      req(addi(11), 10);
      iReady = 1'b1;
      req(addi(12), 10);
      iReady = 1'b0;
      chk("half_ready", 32'(oReady), 32'd1);
      req(addi(13), 10);
      chk("three_ready", 32'(oReady), 32'd1);
      req(addi(14), 10);
      chk("half_full_ready", 32'(oReady), 32'd0);
      drain();

      // Reject counter saturation.
      bad = mk(OPC_JALR, OPADD, 3'd4, 5'd1, 5'd1, 5'd0, 32'd0, 0, 32'h0);
      for (int k = 0; k < 260; k++) req(bad, 10);
      chk("errcnt_sat", 32'(oErrCnt), 32'd255);

      // Reset with queued traffic and a coincident request.
      iReady = 1'b0;
      for (int k = 0; k < 3; k++) req(addi(20 + k), 10);
      chk("pre_rst_valid", 32'(oValid), 32'd1);
      drive(addi(30));
      iValid = 1'b1;
      iRST = 1'b1;
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      iValid = 1'b0;
      q.delete();
      mcnt = 0;
      merr = 0;
      chk("rst2_valid", 32'(oValid), 32'd0);
      chk("rst2_err", 32'(oErr), 32'd0);
      chk("rst2_errcnt", 32'(oErrCnt), 32'd0);
      chk("rst2_instrcnt", 32'(oInstrCnt), 32'd0);
      chk("rst2_instr", oInstr, 32'h0);
      chk("rst2_ready", 32'(oReady), 32'd1);
      iReady = 1'b1;
      repeat (3) @(posedge iCLK);
      #1;
      chk("rst2_no_output", 32'(oValid), 32'd0);
      req(tbl[0], 10);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
